// File: rtl/word_assembler_if.sv
// Byte-in / word-out bus of the word assembler.
// The master side feeds bytes and flush requests; the slave side is the assembler itself.
interface word_assembler_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        flush;
   logic [31:0] word_out;
   logic        word_load;
   logic [2:0]  word_bytes;
   logic [7:0]  word_count;

   modport master (
      output byte_in, byte_valid, flush,
      input  byte_ready, word_out, word_load, word_bytes, word_count
   );

   modport slave (
      input  byte_in, byte_valid, flush,
      output byte_ready, word_out, word_load, word_bytes, word_count
   );
endinterface

// File: rtl/word_assembler.sv
// Packs 8-bit bytes into 32-bit words for a downstream load-enabled register.
// A flush emits a zero-padded partial word; every emitted word bumps a wrapping counter.
module word_assembler #(
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   word_assembler_if.slave   bus
);

   typedef enum logic {COLLECT, EMIT} state_t;

   state_t      state_q, state_d;
   logic [1:0]  fill_q, fill_d;
   logic [31:0] shadow_q, shadow_d;
   logic [31:0] word_out_q, word_out_d;
   logic [2:0]  word_bytes_q, word_bytes_d;
   logic [7:0]  count_q, count_d;
   logic        ready_q, ready_d;
   logic        load_q, load_d;

   logic        accept;
   logic [1:0]  lane;
   logic [31:0] merged;
   logic        emit;
   logic [31:0] emit_word;
   logic [2:0]  emit_bytes;

   // Byte lanes holding the first n bytes of a word, for the configured byte order.
   function automatic logic [31:0] lane_mask(input logic [2:0] n);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(n)) begin
            if (LITTLE_ENDIAN)
               m[8*i +: 8] = 8'hFF;
            else
               m[8*(3-i) +: 8] = 8'hFF;
         end
      end
      return m;
   endfunction

   always_comb begin
      state_d      = state_q;
      fill_d       = fill_q;
      shadow_d     = shadow_q;
      word_out_d   = word_out_q;
      word_bytes_d = word_bytes_q;
      count_d      = count_q;
      emit         = 1'b0;
      emit_word    = '0;
      emit_bytes   = '0;

      accept = bus.byte_valid && ready_q;
      lane   = LITTLE_ENDIAN ? fill_q : (2'd3 - fill_q);
      merged = shadow_q;
      merged[8*lane +: 8] = bus.byte_in;

      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (fill_q == 2'd3) begin
                  emit       = 1'b1;
                  emit_word  = merged;
                  emit_bytes = 3'd4;
               end else if (bus.flush) begin
                  emit       = 1'b1;
                  emit_word  = merged;
                  emit_bytes = {1'b0, fill_q} + 3'd1;
               end else begin
                  shadow_d = merged;
                  fill_d   = fill_q + 2'd1;
               end
            end else if (bus.flush && (fill_q != 2'd0)) begin
               emit       = 1'b1;
               emit_word  = shadow_q;
               emit_bytes = {1'b0, fill_q};
            end
         end
         EMIT: begin
            state_d = COLLECT;
            count_d = count_q + 8'd1;
         end
         default: state_d = COLLECT;
      endcase

      // Clearing shadow on every emit keeps stale lanes out of later partial words.
      if (emit) begin
         state_d      = EMIT;
         word_out_d   = emit_word & lane_mask(emit_bytes);
         word_bytes_d = emit_bytes;
         shadow_d     = '0;
         fill_d       = '0;
      end

      ready_d = (state_d == COLLECT);
      load_d  = (state_d == EMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         fill_q       <= '0;
         shadow_q     <= '0;
         word_out_q   <= '0;
         word_bytes_q <= '0;
         count_q      <= '0;
         ready_q      <= 1'b0;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         shadow_q     <= shadow_d;
         word_out_q   <= word_out_d;
         word_bytes_q <= word_bytes_d;
         count_q      <= count_d;
         ready_q      <= ready_d;
         load_q       <= load_d;
      end
   end

   assign bus.byte_ready = ready_q;
   assign bus.word_load  = load_q;
   assign bus.word_out   = word_out_q;
   assign bus.word_bytes = word_bytes_q;
   assign bus.word_count = count_q;

endmodule

// File: tb/tb_word_assembler.sv
// Scoreboard bench for word_assembler: a little-endian and a big-endian instance share one
// byte stream; a byte-list model predicts every emitted word, checked by a separate monitor.
module tb_word_assembler;

   logic clk;
   logic rst_n;

   word_assembler_if if_le ();
   word_assembler_if if_be ();

   word_assembler #(.LITTLE_ENDIAN(1'b1)) dut_le (.clk(clk), .rst_n(rst_n), .bus(if_le));
   word_assembler #(.LITTLE_ENDIAN(1'b0)) dut_be (.clk(clk), .rst_n(rst_n), .bus(if_be));

   typedef struct {
      logic [31:0] le;
      logic [31:0] be;
      logic [2:0]  n;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  cur_bytes[$];
   int          model_count;
   int          checks;
   int          errors;
   logic [31:0] prev_le;
   logic [31:0] prev_be;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_emit();
      exp_t e;
      e.le = '0;
      e.be = '0;
      for (int i = 0; i < cur_bytes.size(); i++) begin
         e.le = e.le | (32'(cur_bytes[i]) << (8 * i));
         e.be = e.be | (32'(cur_bytes[i]) << (8 * (3 - i)));
      end
      e.n   = 3'(cur_bytes.size());
      e.cnt = 8'(model_count % 256);
      exp_q.push_back(e);
      model_count++;
      cur_bytes.delete();
   endtask

   // Drives one cycle of stimulus; the transfer decision uses the registered ready seen now.
   task automatic apply_stimulus(input logic [7:0] b, input logic v, input logic f, output logic taken);
      logic rdy;
      @(negedge clk);
      rdy = if_le.byte_ready;
      if_le.byte_in = b;  if_le.byte_valid = v;  if_le.flush = f;
      if_be.byte_in = b;  if_be.byte_valid = v;  if_be.flush = f;
      taken = v && rdy;
      if (taken) begin
         cur_bytes.push_back(b);
         if (cur_bytes.size() == 4 || f) model_emit();
      end else if (f && rdy && cur_bytes.size() > 0) begin
         model_emit();
      end
   endtask

   task automatic send(input logic [7:0] b, input logic v, input logic f);
      logic taken;
      apply_stimulus(b, v, f, taken);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(8'h00, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs();
      check_output("rst le word_out", if_le.word_out, 32'h0);
      check_output("rst le word_bytes", 32'(if_le.word_bytes), 32'h0);
      check_output("rst le word_count", 32'(if_le.word_count), 32'h0);
      check_output("rst le word_load", 32'(if_le.word_load), 32'h0);
      check_output("rst le byte_ready", 32'(if_le.byte_ready), 32'h0);
      check_output("rst be word_out", if_be.word_out, 32'h0);
      check_output("rst be word_count", 32'(if_be.word_count), 32'h0);
      check_output("rst be word_load", 32'(if_be.word_load), 32'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check_output("ready low before first edge", 32'(if_le.byte_ready), 32'h0);
      @(negedge clk);
      check_output("ready after first edge", 32'(if_le.byte_ready), 32'h1);
   endtask

   task automatic assert_reset();
      #2 rst_n = 1'b0;
      if_le.byte_valid = 1'b0;  if_le.flush = 1'b0;
      if_be.byte_valid = 1'b0;  if_be.flush = 1'b0;
      #1 check_reset_outputs();
      check_output("scoreboard empty at reset", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      cur_bytes.delete();
      model_count = 0;
      release_reset();
   endtask

   // Monitor: pops the scoreboard on every load pulse and checks that outputs hold otherwise.
   initial begin
      exp_t e;
      prev_le = '0;
      prev_be = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_le = '0;
            prev_be = '0;
         end else if (if_le.word_load) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected word_load: got word %h expected no load", if_le.word_out);
            end else begin
               e = exp_q.pop_front();
               check_output("le word_out", if_le.word_out, e.le);
               check_output("le word_bytes", 32'(if_le.word_bytes), 32'(e.n));
               check_output("le word_count", 32'(if_le.word_count), 32'(e.cnt));
               check_output("ready in emit", 32'(if_le.byte_ready), 32'h0);
               check_output("be word_load", 32'(if_be.word_load), 32'h1);
               check_output("be word_out", if_be.word_out, e.be);
               check_output("be word_bytes", 32'(if_be.word_bytes), 32'(e.n));
            end
            prev_le = if_le.word_out;
            prev_be = if_be.word_out;
         end else begin
            check_output("be idle load", 32'(if_be.word_load), 32'h0);
            check_output("le word_out hold", if_le.word_out, prev_le);
            check_output("be word_out hold", if_be.word_out, prev_be);
            check_output("ready in collect", 32'(if_le.byte_ready), 32'h1);
         end
      end
   end

   initial begin
      logic taken;
      logic [7:0] b;
      int words;
      checks = 0;
      errors = 0;
      model_count = 0;
      rst_n = 1'b0;
      if_le.byte_in = '0;  if_le.byte_valid = 1'b0;  if_le.flush = 1'b0;
      if_be.byte_in = '0;  if_be.byte_valid = 1'b0;  if_be.flush = 1'b0;
      #1 check_reset_outputs();
      release_reset();

      // Full word in both byte orders.
      send(8'h01, 1'b1, 1'b0);
      send(8'h08, 1'b1, 1'b0);
      send(8'h00, 1'b1, 1'b0);
      send(8'h80, 1'b1, 1'b0);
      idle(2);
      check_output("le full word", if_le.word_out, 32'h80000801);
      check_output("be full word", if_be.word_out, 32'h01080080);
      check_output("count after first word", 32'(if_le.word_count), 32'h1);
      send(8'hAA, 1'b1, 1'b0);
      send(8'hBB, 1'b1, 1'b0);
      send(8'hCC, 1'b1, 1'b0);
      send(8'hDD, 1'b1, 1'b0);
      idle(2);
      check_output("be AABBCCDD", if_be.word_out, 32'hAABBCCDD);

      // Flush of a partial word, then a flush with nothing held.
      send(8'h12, 1'b1, 1'b0);
      send(8'h34, 1'b1, 1'b0);
      send(8'h00, 1'b0, 1'b1);
      idle(2);
      check_output("flush partial word", if_le.word_out, 32'h00003412);
      check_output("flush partial bytes", 32'(if_le.word_bytes), 32'h2);
      send(8'h00, 1'b0, 1'b1);
      idle(2);
      check_output("empty flush count", 32'(if_le.word_count), 32'h3);

      // Byte and flush together at fill 2 and at fill 3.
      send(8'h11, 1'b1, 1'b0);
      send(8'h22, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b1);
      idle(2);
      check_output("byte+flush fill2 bytes", 32'(if_le.word_bytes), 32'h3);
      send(8'h33, 1'b1, 1'b0);
      send(8'h44, 1'b1, 1'b0);
      send(8'h55, 1'b1, 1'b0);
      send(8'hFF, 1'b1, 1'b1);
      idle(2);
      check_output("byte+flush fill3 bytes", 32'(if_le.word_bytes), 32'h4);

      // Reset mid-word, then reset while a word is being emitted.
      send(8'h66, 1'b1, 1'b0);
      send(8'h77, 1'b1, 1'b0);
      @(negedge clk);
      assert_reset();
      send(8'hA1, 1'b1, 1'b0);
      send(8'hA2, 1'b1, 1'b0);
      send(8'hA3, 1'b1, 1'b0);
      send(8'hA4, 1'b1, 1'b0);
      @(negedge clk);
      check_output("load before emit reset", 32'(if_le.word_load), 32'h1);
      assert_reset();

      // Randomised mix of bytes, gaps and flushes.
      for (int i = 0; i < 2000; i++) begin
         send(8'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
      end
      idle(3);

      // Continuous stream with held bytes: exactly 256 words must wrap the counter to 0.
      @(negedge clk);
      assert_reset();
      words = 0;
      while (words < 1024) begin
         b = 8'($urandom);
         taken = 1'b0;
         for (int t = 0; t < 4 && !taken; t++) apply_stimulus(b, 1'b1, 1'b0, taken);
         if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte accept timeout: got no transfer expected transfer");
            words = 1024;
         end else begin
            words++;
         end
      end
      idle(3);
      check_output("word_count wrap", 32'(if_le.word_count), 32'h0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check_output("scoreboard drained", 32'(exp_q.size()), 32'h0);
      check_output("final word_count", 32'(if_le.word_count), 32'(8'(model_count % 256)));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
